// File: rtl/dot_product_sequencer.sv
// Sequencer that drives the 16-bit ALU to compute one dot product sum(A[i][k]*B[k][j]).
// Each element reads A, then B, then issues MUL, then ADD, then accumulates the ALU result.
//
// state  | meaning
// IDLE   | waiting for start; a len=0 start completes here with a zero result
// RDA    | read A[k] at ptr_a
// RDB    | read B[k] at ptr_b, capture A[k]
// WAITB  | capture B[k]
// MUL    | issue opA*opB to the ALU
// ADD    | issue product+acc to the ALU
// ACC    | take the sum into acc, advance pointers; on the last k report result
module dot_product_sequencer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] stride_b,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [1:0]    alu_control,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zflag,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          zero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDA   = 3'd1,
        S_RDB   = 3'd2,
        S_WAITB = 3'd3,
        S_MUL   = 3'd4,
        S_ADD   = 3'd5,
        S_ACC   = 3'd6
    } state_t;

    localparam logic [1:0]    OP_NOP = 2'b00;
    localparam logic [1:0]    OP_MUL = 2'b01;
    localparam logic [1:0]    OP_ADD = 2'b10;
    localparam logic [AW-1:0] ONE    = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_stride_b;
    logic [AW-1:0] r_ptr_a;
    logic [AW-1:0] r_ptr_b;
    logic [AW-1:0] r_k;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_result;
    logic          r_zero;
    logic          r_done;
    logic          w_start_run;
    logic          w_start_empty;
    logic          w_last;

    assign w_start_run   = (r_state == S_IDLE) && start && (len != '0);
    assign w_start_empty = (r_state == S_IDLE) && start && (len == '0);
    assign w_last        = (r_k == (r_len - ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start_run ? S_RDA : S_IDLE;
            S_RDA:   w_next = S_RDB;
            S_RDB:   w_next = S_WAITB;
            S_WAITB: w_next = S_MUL;
            S_MUL:   w_next = S_ADD;
            S_ADD:   w_next = S_ACC;
            S_ACC:   w_next = w_last ? S_IDLE : S_RDA;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd      = 1'b0;
        mem_addr    = '0;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = OP_NOP;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_RDA: begin
                mem_rd   = 1'b1;
                mem_addr = r_ptr_a;
            end
            S_RDB: begin
                mem_rd   = 1'b1;
                mem_addr = r_ptr_b;
            end
            S_MUL: begin
                alu_in1     = r_op_a;
                alu_in2     = r_op_b;
                alu_control = OP_MUL;
            end
            // alu_out holds the product registered at the end of MUL
            S_ADD: begin
                alu_in1     = alu_out;
                alu_in2     = r_acc;
                alu_control = OP_ADD;
            end
            default: begin
                mem_rd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_stride_b <= '0;
            r_ptr_a    <= '0;
            r_ptr_b    <= '0;
            r_k        <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_run) begin
                r_len      <= len;
                r_stride_b <= stride_b;
                r_ptr_a    <= base_a;
                r_ptr_b    <= base_b;
                r_k        <= '0;
                r_acc      <= '0;
            end
            if (w_start_empty) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_done   <= 1'b1;
            end
            if (r_state == S_RDB) begin
                r_op_a <= mem_rdata;
            end
            if (r_state == S_WAITB) begin
                r_op_b <= mem_rdata;
            end
            if (r_state == S_ACC) begin
                r_acc   <= alu_out;
                r_ptr_a <= r_ptr_a + ONE;
                r_ptr_b <= r_ptr_b + r_stride_b;
                r_k     <= r_k + ONE;
                if (w_last) begin
                    r_result <= alu_out;
                    r_zero   <= alu_zflag;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;

endmodule
